svm_vec_loader: RTL
===================

# svm_vec_loader

- Downstream consumer of the ROM data FIFO that the ROM DMA controller fills.
- Pops bytes from the FIFO and packs them little-endian into WORD_WIDTH-bit feature/weight words.
- Hands each word to the SVM datapath over a valid/ready interface, tagged with its index.
- Signals completion once a configured number of words has been delivered.

## Interface
Parameters:
- FIFO_DATA_WIDTH, 8, width of one FIFO entry (one ROM byte)
- BYTES_PER_WORD, 2, FIFO entries per output word (≥1)
- MAX_WORDS, 64, largest word count per load
- WORD_WIDTH, FIFO_DATA_WIDTH*BYTES_PER_WORD, output word width (derived)
- CNT_WIDTH, $clog2(MAX_WORDS+1), word counter width (derived)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- fifo_data_out  in  FIFO_DATA_WIDTH  FIFO head; valid whenever fifo_empty=0 (first-word-fall-through)
- fifo_empty  in  1  FIFO empty flag
- fifo_data_pop  out  1  pop strobe; consumes head this cycle
- start_load  in  1  one-cycle start pulse
- abort  in  1  synchronous abort, returns to IDLE
- cfg_num_words  in  CNT_WIDTH  words to deliver; sampled on start_load
- vec_word_data  out  WORD_WIDTH  assembled word
- vec_word_valid  out  1  word available
- vec_word_ready  in  1  datapath accepts word
- vec_word_idx  out  CNT_WIDTH  index of the current word, 0-based
- vec_word_last  out  1  current word is the final word
- busy  out  1  high in any state other than IDLE
- load_done  out  1  one-cycle pulse after the final handshake

## Operation
- States: IDLE, ASSEMBLE, OUTPUT, DONE.
- IDLE:
  - On start_load, latch cfg_num_words into num_words_q and clear word_cnt and byte_cnt.
  - If cfg_num_words=0, go to DONE; otherwise go to ASSEMBLE.
  - start_load is ignored in every state except IDLE.
- ASSEMBLE:
  - fifo_data_pop = !fifo_empty (combinational).
  - On each pop, write fifo_data_out into byte lane byte_cnt of word_q. Lane 0 is bits [FIFO_DATA_WIDTH-1:0].
  - After the pop with byte_cnt=BYTES_PER_WORD-1, clear byte_cnt and go to OUTPUT. Otherwise increment byte_cnt.
  - An empty FIFO stalls the state with no pop; partial bytes are held.
- OUTPUT:
  - vec_word_valid=1, vec_word_data=word_q, vec_word_idx=word_cnt, vec_word_last=(word_cnt==num_words_q-1).
  - Data and idx stay stable until the handshake (valid & ready).
  - On the handshake: if last, go to DONE; else increment word_cnt and go to ASSEMBLE.
  - fifo_data_pop=0 in this state; no prefetch.
- DONE:
  - load_done=1 for one cycle, then go to IDLE.
- abort has priority over all other transitions:
  - Next state is IDLE; counters and word_q cleared; no load_done.
  - A pop already issued in the same cycle still consumes its byte.
- word_cnt and byte_cnt increments never wrap, because they are bounded by num_words_q and BYTES_PER_WORD.
- cfg_num_words > MAX_WORDS is clamped to MAX_WORDS at latch.

## Timing
- Reset values: fifo_data_pop=0, vec_word_valid=0, vec_word_data=0, vec_word_idx=0, vec_word_last=0, busy=0, load_done=0, state=IDLE.
- start_load at cycle T → busy=1 at T+1. The first pop can occur at T+1.
- With the FIFO non-empty throughout, pops occur at T+1..T+B, where B=BYTES_PER_WORD, and vec_word_valid rises at T+B+1.
- Peak throughput is one word per B+1 cycles, with ready tied high.
- Final handshake at cycle H → load_done=1 at H+1 → busy=0 at H+2.
- Zero-count load: start_load at T → load_done at T+1, with no pops.
- All outputs are registered except fifo_data_pop, and except vec_word_valid, vec_word_last and busy, which are decoded from the registered state.

## Structure
- Package svm_pkg holds:
  - typedef enum t_vec_loader_states {IDLE, ASSEMBLE, OUTPUT, DONE}
  - FIFO_DATA_WIDTH, which is shared with the ROM DMA controller and the FIFO
- The block is a single module with no sub-modules. The byte-lane write is an indexed part-select on word_q.

## Test plan
- Reset with the FIFO preloaded with 8 bytes → all outputs 0 until start_load.
- cfg_num_words=4, B=2, FIFO bytes 0x11,0x22,…,0x88, ready=1 → words 0x2211, 0x4433, 0x6655, 0x8877 with idx 0..3, last only on idx 3, then load_done one cycle later.
- FIFO empty mid-word (after 0x11), 0x22 arrives 5 cycles later → no pop while empty, then word 0x2211 is output once.
- vec_word_ready held low for 10 cycles in OUTPUT → data and idx stable, no pops, word delivered on the first ready.
- cfg_num_words=0 → load_done at T+1, no pops. A second start_load issued while busy is ignored.
- abort in the cycle after the first word's handshake → IDLE next cycle, busy=0, no load_done; a subsequent start_load resumes cleanly from idx 0.

Source files
------------

// File: rtl/svm_pkg.sv
// Shared types and widths for the SVM feature-loading path.
// FIFO_DATA_WIDTH is common to the ROM DMA controller, the ROM data FIFO and the vector loader.
package svm_pkg;

    localparam int FIFO_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        ASSEMBLE,
        OUTPUT,
        DONE
    } t_vec_loader_states;

endpackage

// File: rtl/svm_vec_loader.sv
// Pops ROM bytes from a first-word-fall-through FIFO, packs them little-endian into words
// and hands each word, tagged with its index, to the SVM datapath over valid/ready.
module svm_vec_loader #(
    parameter int FIFO_DATA_WIDTH = svm_pkg::FIFO_DATA_WIDTH,
    parameter int BYTES_PER_WORD  = 2,
    parameter int MAX_WORDS       = 64,
    parameter int WORD_WIDTH      = FIFO_DATA_WIDTH * BYTES_PER_WORD,
    parameter int CNT_WIDTH       = $clog2(MAX_WORDS + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_data_out,
    input  logic                       fifo_empty,
    output logic                       fifo_data_pop,
    input  logic                       start_load,
    input  logic                       abort,
    input  logic [CNT_WIDTH-1:0]       cfg_num_words,
    output logic [WORD_WIDTH-1:0]      vec_word_data,
    output logic                       vec_word_valid,
    input  logic                       vec_word_ready,
    output logic [CNT_WIDTH-1:0]       vec_word_idx,
    output logic                       vec_word_last,
    output logic                       busy,
    output logic                       load_done
);

    import svm_pkg::*;

    localparam int BCNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [BCNT_W-1:0]    LAST_LANE = BCNT_W'(BYTES_PER_WORD - 1);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT   = CNT_WIDTH'(MAX_WORDS);

    t_vec_loader_states state_q, state_d;

    logic [CNT_WIDTH-1:0]  num_words_q;
    logic [CNT_WIDTH-1:0]  word_cnt_q;
    logic [BCNT_W-1:0]     byte_cnt_q;
    logic [WORD_WIDTH-1:0] word_q;
    logic                  load_done_q;
    logic                  is_last;
    logic                  handshake;

    function automatic logic [CNT_WIDTH-1:0] clamp_words(input logic [CNT_WIDTH-1:0] n);
        return (n > MAX_CNT) ? MAX_CNT : n;
    endfunction

    assign is_last   = (word_cnt_q == num_words_q - 1'b1);
    assign handshake = vec_word_valid & vec_word_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        fifo_data_pop  = 1'b0;
        vec_word_valid = 1'b0;
        vec_word_last  = 1'b0;
        busy           = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start_load) begin
                    state_d = (cfg_num_words == '0) ? DONE : ASSEMBLE;
                end
            end
            ASSEMBLE: begin
                fifo_data_pop = !fifo_empty;
                if (!fifo_empty && byte_cnt_q == LAST_LANE) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                vec_word_valid = 1'b1;
                vec_word_last  = is_last;
                if (vec_word_ready) begin
                    state_d = is_last ? DONE : ASSEMBLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort wins over every transition; a pop already decoded this cycle still goes out.
        if (abort) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_words_q <= '0;
            word_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            load_done_q <= 1'b0;
        end else begin
            load_done_q <= (state_d == DONE);
            if (abort) begin
                word_cnt_q <= '0;
                byte_cnt_q <= '0;
                word_q     <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_load) begin
                            num_words_q <= clamp_words(cfg_num_words);
                            word_cnt_q  <= '0;
                            byte_cnt_q  <= '0;
                        end
                    end
                    ASSEMBLE: begin
                        if (fifo_data_pop) begin
                            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                                if (byte_cnt_q == BCNT_W'(i)) begin
                                    word_q[i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH] <= fifo_data_out;
                                end
                            end
                            byte_cnt_q <= (byte_cnt_q == LAST_LANE) ? '0 : byte_cnt_q + 1'b1;
                        end
                    end
                    OUTPUT: begin
                        if (handshake && !is_last) begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign vec_word_data = word_q;
    assign vec_word_idx  = word_cnt_q;
    assign load_done     = load_done_q;

endmodule
